seg_scan_decoder: RTL and testbench

- Receive end of the multiplexed 7-segment scan bus: snoops active-low segment/enable lines driven by the display scanner and reconstructs the 8 BCD digits being shown.
- Used for on-board self-check of the score/timer display path and by the verification bench as a display monitor.
- Holds the last decoded value per digit position, with valid flags, an update strobe and error reporting.

---
 rtl/seg_scan_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of a multiplexed 7-segment scan bus.
// Snoops the active-low segment/enable lines and rebuilds the 8 BCD digits
// being displayed.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   segment[7:0]     {a,b,c,d,e,f,g,DP}, active low
//   enable[7:0]      digit7..digit0 select, active low, one-hot-low when legal
//   digit7..digit0   decoded value per position (0-9, F blank, E undecodable)
//   digit_valid      position captured since reset/timeout
//   update           one-cycle pulse per capture
//   frame_done       one-cycle pulse when all 8 positions have been captured
//   err              one-cycle pulse on illegal enable or undecodable segments
//   dp[7:0]          captured decimal points (only with SEG_SCAN_DP_CAPTURE_EN)
//
// Optional feature macro: SEG_SCAN_DP_CAPTURE_EN.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] segment,
    input  logic [7:0] enable,
    output logic [3:0] digit7,
    output logic [3:0] digit6,
    output logic [3:0] digit5,
    output logic [3:0] digit4,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [7:0] digit_valid,
    output logic       update,
    output logic       frame_done,
`ifdef SEG_SCAN_DP_CAPTURE_EN
    output logic [7:0] dp,
`endif
    output logic       err
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] SettleMax = CntW'(SETTLE_CYCLES);
    localparam logic [ToW-1:0]  ToMax     = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

    state_e          state_q, state_d;
    logic [15:0]     sync1_q, sync2_q, prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [ToW-1:0]  to_q, to_d;
    logic [7:0][3:0] digits_q, digits_d;
    logic [7:0]      valid_q, valid_d, seen_q, seen_d;
    logic            update_q, update_d, frame_q, frame_d, err_q, err_d;
`ifdef SEG_SCAN_DP_CAPTURE_EN
    logic [7:0]      dp_q, dp_d;
`endif

    logic [7:0] en, prev_en;
    logic       chg, legal, multi, prev_multi, reach, capture;
    logic [2:0] pos;
    logic [3:0] dec;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        logic [3:0] v;
        case (s)
            7'b0000001: v = 4'd0;
            7'b1001111: v = 4'd1;
            7'b0010010: v = 4'd2;
            7'b0000110: v = 4'd3;
            7'b1001100: v = 4'd4;
            7'b0100100: v = 4'd5;
            7'b0100000: v = 4'd6;
            7'b0001111: v = 4'd7;
            7'b0000000: v = 4'd8;
            7'b0000100: v = 4'd9;
            7'b1111111: v = 4'hF;
            default:    v = 4'hE;
        endcase
        return v;
    endfunction

    always_comb begin
        en         = sync2_q[15:8];
        prev_en    = prev_q[15:8];
        chg        = (sync2_q != prev_q);
        legal      = $onehot(~en);
        multi      = !legal && (en != 8'hFF);
        prev_multi = !$onehot(~prev_en) && (prev_en != 8'hFF);
        dec        = seg_decode(sync2_q[7:1]);
        pos        = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!en[i]) pos = 3'(i);
        end
    end

    // Stability counter: length of the current run of identical samples.
    always_comb begin
        cnt_d = cnt_q;
        if (chg) begin
            cnt_d = CntW'(1);
        end else if (cnt_q != SettleMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Capture happens only on the edge where the run length first reaches
    // SETTLE_CYCLES; once saturated the run never re-triggers.
    assign reach   = (cnt_d == SettleMax) && (chg || (cnt_q != SettleMax));
    assign capture = legal && reach;

    always_comb begin
        state_d = state_q;
        if (!legal) begin
            state_d = StIdle;
        end else if (capture) begin
            state_d = StHeld;
        end else if (chg || (state_q == StIdle)) begin
            state_d = StSettle;
        end
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        to_d     = to_q;
        update_d = 1'b0;
        frame_d  = 1'b0;
        // Illegal enable reports once, on the first cycle of a multi-zero run.
        err_d    = multi && !prev_multi;
`ifdef SEG_SCAN_DP_CAPTURE_EN
        dp_d     = dp_q;
`endif
        if (capture) begin
            digits_d[pos] = dec;
            valid_d[pos]  = 1'b1;
            seen_d[pos]   = 1'b1;
            update_d      = 1'b1;
            err_d         = (dec == 4'hE);
            to_d          = '0;
`ifdef SEG_SCAN_DP_CAPTURE_EN
            dp_d[pos]     = ~sync2_q[0];
`endif
            if (seen_d == 8'hFF) begin
                frame_d = 1'b1;
                seen_d  = 8'h00;
            end
        end else if (to_q == ToMax) begin
            to_d    = '0;
            valid_d = 8'h00;
            seen_d  = 8'h00;
        end else begin
            to_d = to_q + ToW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 16'hFFFF;
            sync2_q  <= 16'hFFFF;
            prev_q   <= 16'hFFFF;
            state_q  <= StIdle;
            cnt_q    <= '0;
            to_q     <= '0;
            digits_q <= {8{4'hF}};
            valid_q  <= 8'h00;
            seen_q   <= 8'h00;
            update_q <= 1'b0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEG_SCAN_DP_CAPTURE_EN
            dp_q     <= 8'h00;
`endif
        end else begin
            sync1_q  <= {enable, segment};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            update_q <= update_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
`ifdef SEG_SCAN_DP_CAPTURE_EN
            dp_q     <= dp_d;
`endif
        end
    end

    assign digit7      = digits_q[7];
    assign digit6      = digits_q[6];
    assign digit5      = digits_q[5];
    assign digit4      = digits_q[4];
    assign digit3      = digits_q[3];
    assign digit2      = digits_q[2];
    assign digit1      = digits_q[1];
    assign digit0      = digits_q[0];
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign frame_done  = frame_q;
    assign err         = err_q;
`ifdef SEG_SCAN_DP_CAPTURE_EN
    assign dp          = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios with literal
// expectations plus randomized scan traffic, all checked every cycle against
// a run-length based behavioural model of the display bus.
module tb_seg_scan_decoder;

    localparam int unsigned Settle  = 4;
    localparam int unsigned Timeout = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] segment = 8'hFF;
    logic [7:0] enable  = 8'hFF;
    logic [3:0] digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0;
    logic [7:0] digit_valid;
    logic       update, frame_done, err;
`ifdef SEG_SCAN_DP_CAPTURE_EN
    logic [7:0] dp;
`endif

    seg_scan_decoder #(
        .SETTLE_CYCLES (Settle),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .segment    (segment),
        .enable     (enable),
        .digit7     (digit7),
        .digit6     (digit6),
        .digit5     (digit5),
        .digit4     (digit4),
        .digit3     (digit3),
        .digit2     (digit2),
        .digit1     (digit1),
        .digit0     (digit0),
        .digit_valid(digit_valid),
        .update     (update),
        .frame_done (frame_done),
`ifdef SEG_SCAN_DP_CAPTURE_EN
        .dp         (dp),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Segment patterns {a..g} for digits 0-9, active low.
    logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    function automatic int zeros(input logic [7:0] e);
        int z = 0;
        for (int i = 0; i < 8; i++) if (e[i] == 1'b0) z++;
        return z;
    endfunction

    function automatic logic [3:0] model_dec(input logic [6:0] s);
        if (s == 7'h7F) return 4'hF;
        for (int d = 0; d < 10; d++) if (pat[d] == s) return 4'(d);
        return 4'hE;
    endfunction

    // Behavioural model. xs[k] is the bus value sampled k edges ago and rl[k]
    // the length of the run of identical samples ending there. The
    // synchronizer makes the decoder act on the sample two edges old; a
    // capture happens when that sample's run length reaches Settle.
    logic [15:0]     xs [4];
    int              rl [4];
    logic [7:0][3:0] m_dig;
    logic [7:0]      m_valid, m_seen;
    int              m_idle;
    logic            m_upd, m_frame, m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                xs[k] = 16'hFFFF;
                rl[k] = 0;
            end
            m_dig   = {8{4'hF}};
            m_valid = 8'h00;
            m_seen  = 8'h00;
            m_idle  = 0;
            m_upd   = 1'b0;
            m_frame = 1'b0;
            m_err   = 1'b0;
        end else begin
            logic [3:0] v;
            int         p;
            for (int k = 3; k > 0; k--) begin
                xs[k] = xs[k-1];
                rl[k] = rl[k-1];
            end
            xs[0] = {enable, segment};
            rl[0] = (xs[0] == xs[1]) ? ((rl[1] < 1000) ? rl[1] + 1 : rl[1]) : 1;
            m_upd   = 1'b0;
            m_frame = 1'b0;
            m_err   = (zeros(xs[2][15:8]) > 1) && !(zeros(xs[3][15:8]) > 1);
            if (zeros(xs[2][15:8]) == 1 && rl[2] == int'(Settle)) begin
                p = 0;
                for (int i = 0; i < 8; i++) if (xs[2][8+i] == 1'b0) p = i;
                v = model_dec(xs[2][7:1]);
                m_dig[p]   = v;
                m_valid[p] = 1'b1;
                m_seen[p]  = 1'b1;
                m_upd      = 1'b1;
                m_err      = (v == 4'hE);
                m_idle     = 0;
                if (m_seen == 8'hFF) begin
                    m_frame = 1'b1;
                    m_seen  = 8'h00;
                end
            end else begin
                m_idle++;
                if (m_idle == int'(Timeout)) begin
                    m_valid = 8'h00;
                    m_seen  = 8'h00;
                    m_idle  = 0;
                end
            end
        end
    end

    logic [31:0] dut_digits;
    assign dut_digits = {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_digits", dut_digits, m_dig);
            chk("cyc_valid", {24'h0, digit_valid}, {24'h0, m_valid});
            chk("cyc_update", {31'h0, update}, {31'h0, m_upd});
            chk("cyc_frame_done", {31'h0, frame_done}, {31'h0, m_frame});
            chk("cyc_err", {31'h0, err}, {31'h0, m_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] en, input logic [7:0] seg);
        @(negedge clk);
        enable  = en;
        segment = seg;
    endtask

    task automatic wait_update(input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (update) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  cnt_u, cnt_e, cnt_f, frame_at;
        bit  found;
        logic [7:0] ren, rseg;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_digits", dut_digits, 32'hFFFF_FFFF);
        chk("rst_valid", {24'h0, digit_valid}, 32'h0);
        chk("rst_pulses", {29'h0, update, frame_done, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();

        // Single stable digit: capture exactly 6 clocks after the input edge.
        drive(8'hFE, 8'b10011111);
        repeat (5) step();
        chk("t1_no_early_update", {31'h0, update}, 32'h0);
        step();
        chk("t1_update", {31'h0, update}, 32'h1);
        chk("t1_digit0", {28'h0, digit0}, 32'h1);
        chk("t1_valid", {24'h0, digit_valid}, 32'h01);
        chk("t1_model_valid", {24'h0, m_valid}, 32'h01);
        chk("t1_model_digit0", {28'h0, m_dig[0]}, 32'h1);
        cnt_u = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (update) cnt_u++;
        end
        chk("t1_single_update", cnt_u, 0);

        // Full scan showing 7..0 on digit7..digit0.
        cnt_u = 0; cnt_f = 0; frame_at = 0;
        for (int p = 7; p >= 0; p--) begin
            drive(~(8'h01 << p), {pat[p], 1'b1});
            for (int i = 0; i < 10; i++) begin
                step();
                if (update) cnt_u++;
                if (frame_done) begin
                    cnt_f++;
                    frame_at = update ? cnt_u : -1;
                end
            end
        end
        chk("scan_updates", cnt_u, 8);
        chk("scan_frames", cnt_f, 1);
        chk("scan_frame_with_8th", frame_at, 8);
        chk("scan_digits", dut_digits, 32'h7654_3210);
        chk("scan_model_digits", m_dig, 32'h7654_3210);
        chk("scan_valid", {24'h0, digit_valid}, 32'hFF);

        // Illegal two-zero enable.
        drive(8'hFC, 8'b00000011);
        cnt_u = 0; cnt_e = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (update) cnt_u++;
            if (err) cnt_e++;
        end
        chk("ill_err_once", cnt_e, 1);
        chk("ill_no_update", cnt_u, 0);
        chk("ill_digits_kept", dut_digits, 32'h7654_3210);

        // Undecodable segments.
        drive(8'hFB, 8'b01100001);
        wait_update(20, found);
        chk("undec_seen", {31'h0, found}, 32'h1);
        chk("undec_err_with_update", {31'h0, err}, 32'h1);
        chk("undec_digit2", {28'h0, digit2}, 32'hE);

        // Blank is legal.
        drive(8'hF7, 8'hFF);
        wait_update(20, found);
        chk("blank_seen", {31'h0, found}, 32'h1);
        chk("blank_no_err", {31'h0, err}, 32'h0);
        chk("blank_digit3", {28'h0, digit3}, 32'hF);

        // Glitching segments: no capture until stable.
        cnt_u = 0;
        for (int i = 0; i < 10; i++) begin
            drive(8'hFE, (i % 2 == 1) ? {pat[8], 1'b1} : {pat[3], 1'b1});
            step();
            if (update) cnt_u++;
            step();
            if (update) cnt_u++;
        end
        chk("glitch_no_update", cnt_u, 0);
        wait_update(20, found);
        chk("glitch_settled", {31'h0, found}, 32'h1);
        chk("glitch_digit0", {28'h0, digit0}, 32'h8);

        // Timeout clears valid flags but keeps values.
        drive(8'hDF, {pat[9], 1'b1});
        wait_update(20, found);
        chk("to_capture", {31'h0, found}, 32'h1);
        chk("to_digit5", {28'h0, digit5}, 32'h9);
        drive(8'hFF, 8'hFF);
        repeat (55) step();
        chk("to_valid_clear", {24'h0, digit_valid}, 32'h0);
        chk("to_digit5_kept", {28'h0, digit5}, 32'h9);

        // Reset in the middle of settling, then a full-latency capture.
        drive(8'hFD, {pat[4], 1'b1});
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_digits", dut_digits, 32'hFFFF_FFFF);
        chk("mid_rst_valid", {24'h0, digit_valid}, 32'h0);
        chk("mid_rst_pulses", {29'h0, update, frame_done, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step();
        chk("post_rst_no_early", {31'h0, update}, 32'h0);
        step();
        chk("post_rst_update", {31'h0, update}, 32'h1);
        chk("post_rst_digit1", {28'h0, digit1}, 32'h4);
        chk("post_rst_valid", {24'h0, digit_valid}, 32'h02);

        // Random scan traffic, checked every cycle by the model.
        for (int n = 0; n < 300; n++) begin
            int r, a, b;
            r = int'($urandom_range(0, 9));
            a = int'($urandom_range(0, 7));
            if (r == 0) begin
                ren = 8'hFF;
            end else if (r == 1) begin
                b   = (a + 1 + int'($urandom_range(0, 6))) % 8;
                ren = ~((8'h01 << a) | (8'h01 << b));
            end else begin
                ren = ~(8'h01 << a);
            end
            if ($urandom_range(0, 7) == 0) begin
                rseg = 8'($urandom);
            end else begin
                rseg = {pat[$urandom_range(0, 9)], 1'($urandom)};
            end
            drive(ren, rseg);
            repeat ($urandom_range(1, 12)) step();
        end
        drive(8'hFF, 8'hFF);
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
